// File: rtl/fm_sb_pkg.sv
// Shared types and helpers for the fast-monitoring tap serializer.
package fm_sb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } fm_tap_state_t;

  localparam int FM_TAP_DROP_CNT_W = 16;

  // Number of OUT_WIDTH words needed to carry one IN_WIDTH record.
  function automatic int fm_tap_words(input int in_w, input int out_w);
    return (in_w + out_w - 1) / out_w;
  endfunction

endpackage

// File: rtl/fm_tap_serializer_if.sv
// Tap-side record inputs and spy-buffer word outputs of one fm_tap_serializer.
// Valid/ready: no ready exists in either direction; in_valid is a strobe taken when
// enable=1 and the FIFO has room, and every fm_valid word is consumed downstream.
interface fm_tap_serializer_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32
);
  import fm_sb_pkg::*;

  logic                         enable;
  logic                         in_valid;
  logic [IN_WIDTH-1:0]          in_data;
  logic                         fm_valid;
  logic                         fm_sop;
  logic                         fm_eop;
  logic [OUT_WIDTH-1:0]         fm_data;
  logic [FM_TAP_DROP_CNT_W-1:0] drop_cnt;
  logic                         busy;
  fm_tap_state_t                dbg_state;

  modport slave (
    input  enable, in_valid, in_data,
    output fm_valid, fm_sop, fm_eop, fm_data, drop_cnt, busy, dbg_state
  );

  modport master (
    output enable, in_valid, in_data,
    input  fm_valid, fm_sop, fm_eop, fm_data, drop_cnt, busy, dbg_state
  );

endinterface

// File: rtl/fm_tap_fifo.sv
// Single-clock record FIFO with full/empty flags; DEPTH must be a power of two.
module fm_tap_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fm_tap_serializer.sv
// Captures tap records into a FIFO and serializes them LSW-first with sop/eop framing.
// Optional FM_TAP_TIMESTAMP_EN prefixes every record with a captured cycle-count header word.
module fm_tap_serializer
  import fm_sb_pkg::*;
#(
  parameter int IN_WIDTH   = 128,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk_hs,
  input  logic                 rst_hs,
  fm_tap_serializer_if.slave   bus
);

  localparam int N  = fm_tap_words(IN_WIDTH, OUT_WIDTH);
  localparam int PW = N * OUT_WIDTH;
`ifdef FM_TAP_TIMESTAMP_EN
  localparam int TSW = 32;
  localparam int NW  = N + 1;
  localparam int FW  = IN_WIDTH + TSW;
`else
  localparam int NW  = N;
  localparam int FW  = IN_WIDTH;
`endif
  localparam int SW = NW * OUT_WIDTH;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  logic                         push, pop, full, empty;
  logic [FW-1:0]                wr_data, rd_data;
  logic [SW-1:0]                load_word;
  fm_tap_state_t                state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [SW-1:0]                sh_q, sh_d;
  logic                         valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [OUT_WIDTH-1:0]         data_q, data_d;
  logic [FM_TAP_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

`ifdef FM_TAP_TIMESTAMP_EN
  logic [TSW-1:0] ts_q;

  always_ff @(posedge clk_hs or posedge rst_hs) begin
    if (rst_hs) ts_q <= '0;
    else        ts_q <= ts_q + TSW'(1);
  end

  assign wr_data   = {ts_q, bus.in_data};
  // Header sits in the lowest word so it leaves the shift register first.
  assign load_word = {PW'(rd_data[IN_WIDTH-1:0]), OUT_WIDTH'(rd_data[FW-1:IN_WIDTH])};
`else
  assign wr_data   = bus.in_data;
  assign load_word = SW'(rd_data);
`endif

  // Fullness is sampled before this edge's pop, so a full FIFO never writes through.
  assign push = bus.in_valid && bus.enable && !full;

  fm_tap_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_hs),
    .rst_i     (rst_hs),
    .push_i    (push),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.in_valid && bus.enable && full && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + FM_TAP_DROP_CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    data_d  = '0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = load_word;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        valid_d = 1'b1;
        sop_d   = (idx_q == '0);
        eop_d   = (idx_q == LAST);
        data_d  = sh_q[OUT_WIDTH-1:0];
        if (idx_q == LAST) begin
          // Back-to-back records reload here so no idle cycle separates them.
          if (!empty) begin
            pop   = 1'b1;
            sh_d  = load_word;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sh_d  = sh_q >> OUT_WIDTH;
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_hs or posedge rst_hs) begin
    if (rst_hs) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sh_q       <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      data_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.fm_valid  = valid_q;
  assign bus.fm_sop    = sop_q;
  assign bus.fm_eop    = eop_q;
  assign bus.fm_data   = data_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.busy      = !empty || (state_q == SEND);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fm_tap_serializer.sv
// Directed bench for fm_tap_serializer (128-bit records, 32-bit words, depth 8).
// Define FM_TAP_TIMESTAMP_EN for both bench and RTL to cover the header-word build.
module tb_fm_tap_serializer;
  import fm_sb_pkg::*;

`ifdef FM_TAP_TIMESTAMP_EN
  localparam int  NW  = 5;
  localparam bit  HDR = 1'b1;
`else
  localparam int  NW  = 4;
  localparam bit  HDR = 1'b0;
`endif
  // Records accepted out of a 13/14-cycle burst starting from an empty, idle block.
  localparam logic [13:0] BURST_MASK = HDR ? 14'h13FF : 14'h07FF;

  logic        clk_hs = 1'b0;
  logic        rst_hs = 1'b1;
  logic [31:0] cyc;
  int          n_cmp = 0;
  int          n_err = 0;
  int          words_seen = 0;
  logic [31:0] first_cyc = '0;
  logic [31:0] last_cyc = '0;
  logic [33:0] exp_q[$];

  typedef struct {
    logic [127:0] data;
    logic [31:0]  w [4];
  } vec_t;
  vec_t vecs [4];

  fm_tap_serializer_if #(.IN_WIDTH(128), .OUT_WIDTH(32)) bus ();

  fm_tap_serializer #(
    .IN_WIDTH   (128),
    .OUT_WIDTH  (32),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_hs (clk_hs),
    .rst_hs (rst_hs),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_hs = ~clk_hs;

  always @(posedge clk_hs or posedge rst_hs) begin
    if (rst_hs) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_hs) begin
    if (!rst_hs && bus.fm_valid) begin
      if (words_seen == 0) first_cyc = cyc;
      last_cyc = cyc;
      words_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%0h, required no word", bus.fm_data);
      end else begin
        chk("word", {30'd0, bus.fm_sop, bus.fm_eop, bus.fm_data}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic push_words(input logic [31:0] w0, w1, w2, w3);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
`ifdef FM_TAP_TIMESTAMP_EN
    exp_q.push_back({2'b10, cyc});
`endif
    for (int j = 0; j < 4; j++)
      exp_q.push_back({(j == 0) && !HDR, j == 3, w[j]});
  endtask

  task automatic burst(input int len, input logic [7:0] tag);
    logic [127:0] d;
    for (int i = 0; i < len; i++) begin
      @(negedge clk_hs);
      d = {tag, 24'(i*4+3), tag, 24'(i*4+2), tag, 24'(i*4+1), tag, 24'(i*4)};
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      if (BURST_MASK[i]) push_words(d[31:0], d[63:32], d[95:64], d[127:96]);
    end
    @(negedge clk_hs);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk_hs);
    while ((bus.busy || bus.fm_valid) && t < 500) begin
      @(negedge clk_hs);
      t++;
    end
    n_cmp++;
    if (t >= 500) begin
      n_err++;
      $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, t);
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Single record with cycle-exact latency and framing checks.
  task automatic single(input string name, input vec_t v);
    @(negedge clk_hs);
    bus.in_valid = 1'b1;
    bus.in_data  = v.data;
    push_words(v.w[0], v.w[1], v.w[2], v.w[3]);
    @(negedge clk_hs);                       // after accept edge k
    bus.in_valid = 1'b0;
    chk({name, "_busy_k"}, 64'(bus.busy), 64'd1);
    chk({name, "_valid_k"}, 64'(bus.fm_valid), 64'd0);
    @(negedge clk_hs);                       // after k+1
    chk({name, "_valid_k1"}, 64'(bus.fm_valid), 64'd0);
    @(negedge clk_hs);                       // after k+2
    chk({name, "_sop_k2"}, {62'd0, bus.fm_valid, bus.fm_sop}, 64'd3);
    repeat (NW-1) @(negedge clk_hs);         // after k+1+NW
    chk({name, "_eop_last"}, {62'd0, bus.fm_valid, bus.fm_eop}, 64'd3);
    chk({name, "_busy_end"}, 64'(bus.busy), 64'd0);
    @(negedge clk_hs);
    chk({name, "_valid_end"}, 64'(bus.fm_valid), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0].data = 128'h00000004_00000003_00000002_00000001;
    vecs[0].w    = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
    vecs[1].data = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    vecs[1].w    = '{32'h9ABCDEF0, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[2].data = {128{1'b1}};
    vecs[2].w    = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[3].data = 128'h80000000_00000000_00000000_00000001;
    vecs[3].w    = '{32'h00000001, 32'h00000000, 32'h00000000, 32'h80000000};

    bus.enable   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    chk("rst_valid", 64'(bus.fm_valid), 64'd0);
    chk("rst_sop_eop", {62'd0, bus.fm_sop, bus.fm_eop}, 64'd0);
    chk("rst_data", 64'(bus.fm_data), 64'd0);
    chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    repeat (3) @(negedge clk_hs);
    rst_hs     = 1'b0;
    bus.enable = 1'b1;

`ifdef FM_TAP_TIMESTAMP_EN
    begin : ts_header
      int t = 0;
      while (cyc != 32'd100 && t < 300) begin
        @(negedge clk_hs);
        t++;
      end
      chk("ts_reach_100", 64'(cyc), 64'd100);
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[0].data;
      push_words(vecs[0].w[0], vecs[0].w[1], vecs[0].w[2], vecs[0].w[3]);
      @(negedge clk_hs);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk_hs);
      chk("ts_header_word", {31'd0, bus.fm_sop, bus.fm_data}, {31'd0, 1'b1, 32'h00000064});
      wait_idle("ts_header");
    end
`endif

    // Table-driven single records
    for (int i = 0; i < 4; i++) begin
      single($sformatf("vec%0d", i), vecs[i]);
      wait_idle($sformatf("vec%0d", i));
    end

    // Overflow burst: 11 accepted, 2 dropped, output gapless
    words_seen = 0;
    burst(13, 8'hA0);
    chk("burst_drop_cnt", 64'(bus.drop_cnt), 64'd2);
    wait_idle("burst");
    chk("burst_words", 64'(words_seen), 64'(11*NW));
    chk("burst_gapless", 64'(last_cyc - first_cyc + 32'd1), 64'(11*NW));

    // enable dropped two cycles into a three-record burst
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_hs);
      bus.enable   = (i < 2);
      bus.in_valid = 1'b1;
      bus.in_data  = {32'hE0 + 32'(i), 32'hE1, 32'hE2, 32'hE3};
      if (i < 2) push_words(32'hE3, 32'hE2, 32'hE1, 32'hE0 + 32'(i));
    end
    @(negedge clk_hs);
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk_hs);
      bus.in_valid = 1'b1;
      @(negedge clk_hs);
      bus.in_valid = 1'b0;
    end
    chk("en_off_drop_cnt", 64'(bus.drop_cnt), 64'd2);
    wait_idle("en_off");

    // Saturation from 0xFFFE with three overflows
    bus.enable = 1'b1;
    @(negedge clk_hs);
    force dut.drop_cnt_q = 16'hFFFE;
    #1;
    release dut.drop_cnt_q;
    words_seen = 0;
    burst(14, 8'hB0);
    chk("sat_drop_cnt", 64'(bus.drop_cnt), 64'hFFFF);
    wait_idle("sat");
    chk("sat_words", 64'(words_seen), 64'(11*NW));

    // Asynchronous reset in the middle of a record
    @(negedge clk_hs);
    bus.in_valid = 1'b1;
    bus.in_data  = vecs[1].data;
    push_words(vecs[1].w[0], vecs[1].w[1], vecs[1].w[2], vecs[1].w[3]);
    @(negedge clk_hs);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk_hs);
    chk("mid_rst_before", 64'(bus.fm_valid), 64'd1);
    #2;
    rst_hs = 1'b1;
    #1;
    chk("mid_rst_outputs", {29'd0, bus.fm_valid, bus.fm_sop, bus.fm_eop, bus.busy, bus.fm_data},
        64'd0);
    chk("mid_rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    exp_q.delete();
    @(negedge clk_hs);
    rst_hs = 1'b0;
    single("post_rst", vecs[3]);
    wait_idle("post_rst");

    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
